// File: rtl/amo_ctrl_if.sv
// ---------------------------------------------------------------------------
// amo_pkg      : shared types for the RV32A atomic-memory-operation sequencer
//                (operation encoding, FSM states, result and memory buses).
// amo_ctrl_if  : bundle of the execute-side request, the data-memory port and
//                the result/status signals of amo_ctrl.
//                Optional port: misaligned (present with AMO_MISALIGN_EN).
// ---------------------------------------------------------------------------

package amo_pkg;

   // Decoded AMO operation; encodings 9..15 are undefined and behave as ADD
   typedef enum logic [3:0] {
      AMOADD_W  = 4'd0,
      AMOSWAP_W = 4'd1,
      AMOXOR_W  = 4'd2,
      AMOAND_W  = 4'd3,
      AMOOR_W   = 4'd4,
      AMOMIN_W  = 4'd5,
      AMOMAX_W  = 4'd6,
      AMOMINU_W = 4'd7,
      AMOMAXU_W = 4'd8
   } amoop_t;

   // Load / compute / store sequence states
   typedef enum logic [1:0] {
      AMO_IDLE = 2'd0,
      AMO_LOAD = 2'd1,
      AMO_CALC = 2'd2,
      AMO_DONE = 2'd3
   } state_t;

   // Pipeline-facing status: stall request and original memory word for rd
   typedef struct packed {
      logic        busy;
      logic [31:0] res;
   } acu_s;

   // Request to the data-memory port
   typedef struct packed {
      logic        rd_en;
      logic        wr_en;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } amo_mem_s;

endpackage : amo_pkg

interface amo_ctrl_if;
   import amo_pkg::*;

   logic     start;
   amoop_t   amoop;
   logic [31:0] addr;
   logic [31:0] rs2;
   logic [31:0] mem_rdata;
   acu_s     acu;
   amo_mem_s mem;
   logic     done;
`ifdef AMO_MISALIGN_EN
   logic     misaligned;
`endif

`ifdef AMO_MISALIGN_EN
   // Execute stage plus memory side: issues requests, returns read data
   modport master (
      output start, amoop, addr, rs2, mem_rdata,
      input  acu, mem, done, misaligned
   );

   // The AMO sequencer itself
   modport slave (
      input  start, amoop, addr, rs2, mem_rdata,
      output acu, mem, done, misaligned
   );
`else
   // Execute stage plus memory side: issues requests, returns read data
   modport master (
      output start, amoop, addr, rs2, mem_rdata,
      input  acu, mem, done
   );

   // The AMO sequencer itself
   modport slave (
      input  start, amoop, addr, rs2, mem_rdata,
      output acu, mem, done
   );
`endif

endinterface : amo_ctrl_if

// File: rtl/amo_ctrl.sv
// ---------------------------------------------------------------------------
// amo_ctrl : sequencer for RV32A atomic memory operations.
//
// Each accepted request runs a fixed IDLE -> LOAD -> CALC -> DONE sequence:
// read the word, combine it with rs2, write the result back and hand the
// original word to rd. busy stalls the pipeline from the issuing cycle on.
//
// Optional feature macro: AMO_MISALIGN_EN
//   defined   : a start with addr[1:0] != 0 jumps straight to DONE with no
//               memory traffic, pulsing done and misaligned, res = 0.
//   undefined : addr[1:0] is ignored; every AMO takes the 3-cycle path.
// ---------------------------------------------------------------------------

module amo_ctrl
   import amo_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   amo_ctrl_if.slave  bus
);

   // ------------------------------------------------------------------------
   // State and latched operands
   // ------------------------------------------------------------------------
   state_t      r_state;
   state_t      w_state_nxt;
   amoop_t      r_amoop;
   logic [29:0] r_addr_word;   // word address; byte offset is always 00
   logic [31:0] r_rs2;
   logic [31:0] r_old;         // original memory word, also drives acu.res
   logic [31:0] r_new;         // value written back in AMO_DONE

   logic        w_accept;
   logic        w_fault;
   logic        w_fault_done;
   logic [31:0] w_new;
   logic [31:0] w_mem_addr;
   acu_s        w_acu;
   amo_mem_s    w_mem;
   logic        w_done;

`ifdef AMO_MISALIGN_EN
   logic        r_mis;         // current DONE belongs to a misaligned request
`endif

   // ------------------------------------------------------------------------
   // Read-modify-write arithmetic
   // ------------------------------------------------------------------------
   function automatic logic [31:0] amo_compute(
      input amoop_t      op,
      input logic [31:0] old_val,
      input logic [31:0] opnd
   );
      logic [31:0] result;
      case (op)
         AMOSWAP_W: result = opnd;
         AMOXOR_W:  result = old_val ^ opnd;
         AMOAND_W:  result = old_val & opnd;
         AMOOR_W:   result = old_val | opnd;
         AMOMIN_W:  result = ($signed(old_val) < $signed(opnd)) ? old_val : opnd;
         AMOMAX_W:  result = ($signed(old_val) > $signed(opnd)) ? old_val : opnd;
         AMOMINU_W: result = (old_val < opnd) ? old_val : opnd;
         AMOMAXU_W: result = (old_val > opnd) ? old_val : opnd;
         // ADD and the undefined encodings 9..15; carry out is dropped
         default:   result = old_val + opnd;
      endcase
      return result;
   endfunction

   assign w_accept   = (r_state == AMO_IDLE) && bus.start;
   assign w_mem_addr = {r_addr_word, 2'b00};

   // The word read in AMO_CALC is combined with rs2 and registered on the
   // same edge that captures it, so the store can go out in AMO_DONE.
   assign w_new = amo_compute(r_amoop, bus.mem_rdata, r_rs2);

`ifdef AMO_MISALIGN_EN
   assign w_fault      = w_accept && (bus.addr[1:0] != 2'b00);
   assign w_fault_done = (r_state == AMO_DONE) && r_mis;
`else
   logic w_unused_addr_lsb;
   assign w_unused_addr_lsb = ^bus.addr[1:0];
   assign w_fault           = 1'b0;
   assign w_fault_done      = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // State register, operand latches and result registers
   // ------------------------------------------------------------------------
   // NOTE: every register here is assigned with <= so all of them sample the
   // pre-edge values of each other; a blocking = would let later statements
   // see already-updated state and silently change the pipeline timing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= AMO_IDLE;
         r_amoop     <= AMOADD_W;
         r_addr_word <= '0;
         r_rs2       <= '0;
         r_old       <= '0;
         r_new       <= '0;
`ifdef AMO_MISALIGN_EN
         r_mis       <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;

         if (w_accept) begin
            r_amoop     <= bus.amoop;
            r_addr_word <= bus.addr[31:2];
            r_rs2       <= bus.rs2;
`ifdef AMO_MISALIGN_EN
            r_mis       <= w_fault;
`endif
         end

         if (w_fault) begin
            r_old <= '0;
         end else if (r_state == AMO_CALC) begin
            r_old <= bus.mem_rdata;
            r_new <= w_new;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   // NOTE: the default assignment first guarantees every path assigns the
   // variable, so no latch is inferred when a case arm leaves it untouched.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         AMO_IDLE: begin
            if (bus.start) begin
               w_state_nxt = w_fault ? AMO_DONE : AMO_LOAD;
            end
         end
         AMO_LOAD: w_state_nxt = AMO_CALC;
         AMO_CALC: w_state_nxt = AMO_DONE;
         AMO_DONE: w_state_nxt = AMO_IDLE;
         default:  w_state_nxt = AMO_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode: memory request, done pulse and stall
   // ------------------------------------------------------------------------
   always_comb begin
      w_mem      = '0;
      w_done     = 1'b0;
      w_acu.busy = bus.start || (r_state != AMO_IDLE);
      w_acu.res  = r_old;
      case (r_state)
         AMO_LOAD: begin
            w_mem.rd_en = 1'b1;
            w_mem.addr  = w_mem_addr;
         end
         AMO_DONE: begin
            w_done = 1'b1;
            if (!w_fault_done) begin
               w_mem.wr_en = 1'b1;
               w_mem.addr  = w_mem_addr;
               w_mem.data  = r_new;
               w_mem.mask  = 4'hF;
            end
         end
         default: begin
            w_mem = '0;
         end
      endcase
   end

   assign bus.acu  = w_acu;
   assign bus.mem  = w_mem;
   assign bus.done = w_done;
`ifdef AMO_MISALIGN_EN
   assign bus.misaligned = w_fault_done;
`endif

endmodule : amo_ctrl

// File: tb/tb_amo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_amo_ctrl : directed, table-driven bench for amo_ctrl. Every AMO in the
// table is walked cycle by cycle (T .. T+4) with the memory read data
// supplied by the bench; hand-written sequences cover start collisions,
// reset during an operation and the sub-word address case.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------

module tb_amo_ctrl;
   import amo_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   amo_ctrl_if bus ();

   amo_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      amoop_t      op;
      logic [31:0] addr;
      logic [31:0] old_val;
      logic [31:0] rs2;
      logic [31:0] exp_new;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.start     = 1'b0;
      bus.amoop     = AMOADD_W;
      bus.addr      = '0;
      bus.rs2       = '0;
      bus.mem_rdata = 32'hDEAD_BEEF;
   endtask

   // One complete AMO, checked in every cycle from T to T+4
   task automatic run_amo(input vec_t v);
      @(negedge clk);                               // cycle T
      bus.start = 1'b1;
      bus.amoop = v.op;
      bus.addr  = v.addr;
      bus.rs2   = v.rs2;
      #1;
      check({v.name, " T busy"}, bus.acu.busy, 1'b1);

      @(negedge clk);                               // T+1: read request
      idle_inputs();
      check({v.name, " T+1 rd_en"}, bus.mem.rd_en, 1'b1);
      check({v.name, " T+1 wr_en"}, bus.mem.wr_en, 1'b0);
      check({v.name, " T+1 addr"},  bus.mem.addr, {v.addr[31:2], 2'b00});
      bus.mem_rdata = v.old_val;

      @(negedge clk);                               // T+2: data sampled
      check({v.name, " T+2 rd_en"}, bus.mem.rd_en, 1'b0);
      check({v.name, " T+2 done"},  bus.done, 1'b0);

      @(negedge clk);                               // T+3: write + done
      bus.mem_rdata = 32'hDEAD_BEEF;
      check({v.name, " T+3 done"},  bus.done, 1'b1);
      check({v.name, " T+3 wr_en"}, bus.mem.wr_en, 1'b1);
      check({v.name, " T+3 rd_en"}, bus.mem.rd_en, 1'b0);
      check({v.name, " T+3 data"},  bus.mem.data, v.exp_new);
      check({v.name, " T+3 mask"},  {28'h0, bus.mem.mask}, 32'h0000_000F);
      check({v.name, " T+3 addr"},  bus.mem.addr, {v.addr[31:2], 2'b00});
      check({v.name, " T+3 res"},   bus.acu.res, v.old_val);

      @(negedge clk);                               // T+4: idle again
      check({v.name, " T+4 done"},  bus.done, 1'b0);
      check({v.name, " T+4 wr_en"}, bus.mem.wr_en, 1'b0);
      check({v.name, " T+4 busy"},  bus.acu.busy, 1'b0);
      check({v.name, " T+4 res hold"}, bus.acu.res, v.old_val);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;

      vecs[0]  = '{"add wrap",   AMOADD_W,  32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
      vecs[1]  = '{"min signed", AMOMIN_W,  32'h0000_0104, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
      vecs[2]  = '{"minu",       AMOMINU_W, 32'h0000_0108, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
      vecs[3]  = '{"swap",       AMOSWAP_W, 32'h0000_010C, 32'h1234_5678, 32'hCAFE_BABE, 32'hCAFE_BABE};
      vecs[4]  = '{"xor",        AMOXOR_W,  32'h0000_0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
      vecs[5]  = '{"and",        AMOAND_W,  32'h0000_0114, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
      vecs[6]  = '{"or",         AMOOR_W,   32'h0000_0118, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
      vecs[7]  = '{"max signed", AMOMAX_W,  32'h0000_011C, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001};
      vecs[8]  = '{"maxu",       AMOMAXU_W, 32'h0000_0120, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
      vecs[9]  = '{"min equal",  AMOMIN_W,  32'h0000_0124, 32'h0000_0005, 32'h0000_0005, 32'h0000_0005};
      vecs[10] = '{"max neg",    AMOMAX_W,  32'h0000_0128, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[11] = '{"op9 as add", amoop_t'(4'd9),  32'h0000_012C, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030};
      vecs[12] = '{"op15 as add", amoop_t'(4'd15), 32'h0000_0130, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};

      // ---------------- reset values ----------------
      rst_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset busy",  bus.acu.busy, 1'b0);
      check("reset res",   bus.acu.res, 32'h0);
      check("reset rd_en", bus.mem.rd_en, 1'b0);
      check("reset wr_en", bus.mem.wr_en, 1'b0);
      check("reset addr",  bus.mem.addr, 32'h0);
      check("reset data",  bus.mem.data, 32'h0);
      check("reset done",  bus.done, 1'b0);
`ifdef AMO_MISALIGN_EN
      check("reset misaligned", bus.misaligned, 1'b0);
`endif
      rst_n = 1'b1;

      // ---------------- table of single AMOs ----------------
      for (int i = 0; i < NVEC; i++) begin
         run_amo(vecs[i]);
      end

      // ---------------- start collisions, then back-to-back ----------------
      @(negedge clk);                               // T
      bus.start = 1'b1; bus.amoop = AMOADD_W; bus.addr = 32'h200; bus.rs2 = 32'd1;
      #1;
      check("b2b T busy", bus.acu.busy, 1'b1);
      @(negedge clk);                               // T+1
      idle_inputs();
      check("b2b T+1 rd_en", bus.mem.rd_en, 1'b1);
      check("b2b T+1 addr",  bus.mem.addr, 32'h200);
      bus.mem_rdata = 32'd10;
      @(negedge clk);                               // T+2: stray start
      bus.start = 1'b1; bus.amoop = AMOSWAP_W; bus.addr = 32'h400; bus.rs2 = 32'h55;
      #1;
      check("b2b T+2 rd_en", bus.mem.rd_en, 1'b0);
      check("b2b T+2 busy",  bus.acu.busy, 1'b1);
      @(negedge clk);                               // T+3: start held, dropped
      bus.mem_rdata = 32'hDEAD_BEEF;
      check("b2b T+3 done",  bus.done, 1'b1);
      check("b2b T+3 wr_en", bus.mem.wr_en, 1'b1);
      check("b2b T+3 rd_en", bus.mem.rd_en, 1'b0);
      check("b2b T+3 data",  bus.mem.data, 32'd11);
      check("b2b T+3 addr",  bus.mem.addr, 32'h200);
      @(negedge clk);                               // T+4: accepted start
      bus.start = 1'b1; bus.amoop = AMOADD_W; bus.addr = 32'h300; bus.rs2 = 32'd3;
      #1;
      check("b2b T+4 rd_en", bus.mem.rd_en, 1'b0);
      check("b2b T+4 wr_en", bus.mem.wr_en, 1'b0);
      check("b2b T+4 done",  bus.done, 1'b0);
      check("b2b T+4 busy",  bus.acu.busy, 1'b1);
      @(negedge clk);                               // T+5
      idle_inputs();
      check("b2b T+5 rd_en", bus.mem.rd_en, 1'b1);
      check("b2b T+5 addr",  bus.mem.addr, 32'h300);
      bus.mem_rdata = 32'd4;
      @(negedge clk);                               // T+6
      check("b2b T+6 rd_en", bus.mem.rd_en, 1'b0);
      @(negedge clk);                               // T+7
      bus.mem_rdata = 32'hDEAD_BEEF;
      check("b2b T+7 done", bus.done, 1'b1);
      check("b2b T+7 data", bus.mem.data, 32'd7);
      check("b2b T+7 res",  bus.acu.res, 32'd4);
      @(negedge clk);                               // T+8
      check("b2b T+8 busy", bus.acu.busy, 1'b0);
      check("b2b T+8 done", bus.done, 1'b0);

      // ---------------- reset while in AMO_CALC ----------------
      @(negedge clk);                               // T
      bus.start = 1'b1; bus.amoop = AMOADD_W; bus.addr = 32'h104; bus.rs2 = 32'd1;
      @(negedge clk);                               // T+1
      idle_inputs();
      bus.mem_rdata = 32'h0000_1234;
      check("rst T+1 rd_en", bus.mem.rd_en, 1'b1);
      @(negedge clk);                               // T+2: AMO_CALC
      rst_n = 1'b0;
      @(negedge clk);                               // T+3
      check("rst busy",  bus.acu.busy, 1'b0);
      check("rst res",   bus.acu.res, 32'h0);
      check("rst rd_en", bus.mem.rd_en, 1'b0);
      check("rst wr_en", bus.mem.wr_en, 1'b0);
      check("rst done",  bus.done, 1'b0);
      check("rst addr",  bus.mem.addr, 32'h0);
      check("rst data",  bus.mem.data, 32'h0);
      check("rst mask",  {28'h0, bus.mem.mask}, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst after wr_en", bus.mem.wr_en, 1'b0);
         check("rst after done",  bus.done, 1'b0);
      end

      // ---------------- sub-word address 0x102 ----------------
`ifdef AMO_MISALIGN_EN
      @(negedge clk);                               // T
      bus.start = 1'b1; bus.amoop = AMOADD_W; bus.addr = 32'h102; bus.rs2 = 32'd1;
      #1;
      check("mis T busy", bus.acu.busy, 1'b1);
      @(negedge clk);                               // T+1: fault done
      idle_inputs();
      check("mis T+1 done",       bus.done, 1'b1);
      check("mis T+1 misaligned", bus.misaligned, 1'b1);
      check("mis T+1 rd_en",      bus.mem.rd_en, 1'b0);
      check("mis T+1 wr_en",      bus.mem.wr_en, 1'b0);
      check("mis T+1 res",        bus.acu.res, 32'h0);
      @(negedge clk);                               // T+2
      check("mis T+2 done",       bus.done, 1'b0);
      check("mis T+2 misaligned", bus.misaligned, 1'b0);
      check("mis T+2 busy",       bus.acu.busy, 1'b0);
      check("mis T+2 rd_en",      bus.mem.rd_en, 1'b0);
      // an aligned AMO afterwards runs normally without the fault flag
      run_amo('{"post fault add", AMOADD_W, 32'h0000_0100, 32'h0000_0008, 32'h0000_0001, 32'h0000_0009});
`else
      run_amo('{"offset 0x102", AMOADD_W, 32'h0000_0102, 32'h0000_0008, 32'h0000_0001, 32'h0000_0009});
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_amo_ctrl

// File: doc/amo_ctrl.md
# amo_ctrl

Sequencing unit for RV32A atomic memory operations (AMOs). Sits between the execute stage and the data-memory port. Takes a decoded `amoop_t` and performs the read-modify-write as a fixed load / compute / store sequence. It returns the original memory word for write-back to rd, and asserts `acu.busy` so the pipeline stalls for the duration.

## Interface
Parameters:
- none (data width fixed at 32; memory read latency fixed at 1 cycle)

Ports (`acu_s`, `amo_mem_s`, `amoop_t` are from `amo_pkg`):
- `clk`  in  1  core clock; single clock domain, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  single-cycle request from execute; sampled only in AMO_IDLE
- `amoop`  in  4 (`amoop_t`)  operation, sampled with `start`
- `addr`  in  32  word address of the AMO, sampled with `start`
- `rs2`  in  32  operand, sampled with `start`
- `mem_rdata`  in  32  memory read data, valid the cycle after `mem.rd_en`
- `acu`  out  33 (`acu_s`)  `busy` stall request; `res` original memory word for rd
- `mem`  out  70 (`amo_mem_s`)  request to the data-memory port
- `done`  out  1  one-cycle pulse; `acu.res` is valid in this cycle
- `misaligned`  out  1  one-cycle fault pulse; port present only with AMO_MISALIGN_EN

## Operation
- FSM uses the package `state_t`: AMO_IDLE -> AMO_LOAD -> AMO_CALC -> AMO_DONE -> AMO_IDLE. There are no other transitions except reset, and the fault path below.
- AMO_IDLE, when `start`=1: latch `amoop`, `addr`, `rs2`, then go to AMO_LOAD.
- AMO_LOAD: drive `mem.rd_en`=1 and `mem.addr`={addr[31:2],2'b00}.
- AMO_CALC:
  - capture `mem_rdata` into register `old`
  - compute `new` combinationally from `old` and latched `rs2`
  - register `new`
- AMO_DONE:
  - drive `mem.wr_en`=1, `mem.addr` as above, `mem.data`=`new`, `mem.mask`=4'hF
  - `done`=1
  - `acu.res`=`old`
- Compute rules:
  - ADD: `old`+`rs2` mod 2^32, carry dropped
  - SWAP: `rs2`
  - XOR, AND, OR: bitwise
  - MIN, MAX: signed two's-complement compare
  - MINU, MAXU: unsigned compare
  - equal operands: result is that value
- Undefined `amoop` encodings 9–15 execute as AMOADD_W.
- `acu.busy` = `start` | (state != AMO_IDLE). It is combinational so that the issuing cycle already stalls.
- `acu.res` is registered and holds its value until the next AMO_DONE.
- Outside their active states, `mem` fields are 0; `rd_en` and `wr_en` are never high together.
- `start` while not in AMO_IDLE is ignored. No queuing, and latched operands are unchanged.
- Reset is synchronous. While `rst_n`=0 at a clock edge: state goes to AMO_IDLE, `old`, `new` and `acu.res` go to 0, and all outputs go to 0. A reset during AMO_CALC or AMO_DONE aborts the operation, and no write is issued after reset.

## Timing
- `start` at cycle T:
  - T: `acu.busy`=1
  - T+1: `rd_en` asserted
  - T+2: `mem_rdata` sampled
  - T+3: `wr_en`=1 and `done`=1
  - T+4: back in AMO_IDLE
- Latency from `start` to `done` is 3 cycles. Throughput is one AMO per 4 cycles.
- Back-to-back: a `start` in cycle T+4 is accepted. A `start` in cycle T+3 is dropped.
- Reset values:
  - `acu`=0
  - `mem`=0
  - `done`=0
  - `misaligned`=0

## Configuration
- Macro `AMO_MISALIGN_EN`.
- Defined:
  - `misaligned` port exists.
  - `start` with `addr[1:0]`!=0 goes AMO_IDLE -> AMO_DONE, with no `rd_en` and no `wr_en`.
  - In that AMO_DONE cycle, `done`=1 and `misaligned`=1, and `acu.res` is loaded with 0.
  - Fault latency is 1 cycle.
- Undefined: port absent, `addr[1:0]` ignored, and every AMO takes the normal 3-cycle path.

## Test plan
- AMOADD_W, mem[0x100]=0xFFFFFFFF, rs2=2:
  - expected: `wr_en` data 0x00000001 at T+3; `acu.res`=0xFFFFFFFF; `done` high exactly 1 cycle
- AMOMIN_W vs AMOMINU_W, old=0x80000000, rs2=0x00000001:
  - expected: MIN writes 0x80000000; MINU writes 0x00000001
- AMOSWAP_W, old=0x12345678, rs2=0xCAFEBABE:
  - expected: write 0xCAFEBABE, mask 4'hF, `acu.res`=0x12345678
- Second `start` pulsed at T+2 during an AMO:
  - expected: ignored; only one `rd_en` and one `wr_en`
  - then `start` at T+4 is accepted, with `rd_en` at T+5
- `rst_n`=0 in AMO_CALC:
  - expected: next cycle AMO_IDLE with all outputs 0; no `wr_en` ever issued
- With `AMO_MISALIGN_EN`, addr=0x102:
  - expected: `done`=`misaligned`=1 at T+1; no memory request
  - without the macro, same stimulus accesses 0x100 normally
